// File: rtl/blackparrot_fpga_host_pkg.sv
// Shared constants and FSM state type for the FPGA host byte-to-AXIL command bridge.
// BLACKPARROT_FPGA_HOST_CMD_CHECKSUM_EN adds a trailing XOR checksum byte to each command.
package blackparrot_fpga_host_pkg;

    localparam logic [7:0] OpWrite       = 8'h01;
    localparam logic [7:0] OpRead        = 8'h02;
    localparam logic [7:0] StatusUnknown = 8'hFF;
    localparam logic [7:0] StatusCsumErr = 8'hEE;

    localparam int unsigned AddrBytes = 4;
    localparam int unsigned DataBytes = 4;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StData,
`ifdef BLACKPARROT_FPGA_HOST_CMD_CHECKSUM_EN
        StCsum,
`endif
        StWrite,
        StBwait,
        StRead,
        StRwait,
        StRdata,
        StStatus
    } state_e;

endpackage

// File: rtl/blackparrot_fpga_host_byte_sipo.sv
// Little-endian byte shift-in register: the first byte shifted lands in the LSB.
// done_o pulses alongside the shift of the final byte.
module blackparrot_fpga_host_byte_sipo
    import blackparrot_fpga_host_pkg::*;
#(
    parameter int unsigned NumBytes = AddrBytes
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    input  logic                    shift_i,
    input  logic [7:0]              byte_i,
    output logic [8*NumBytes-1:0]   data_o,
    output logic                    done_o
);

    localparam int unsigned CntW = (NumBytes > 1) ? $clog2(NumBytes) : 1;

    logic [8*NumBytes-1:0] data_d, data_q;
    logic [CntW-1:0]       cnt_d, cnt_q;

    assign done_o = shift_i && (cnt_q == CntW'(NumBytes - 1));
    assign data_o = data_q;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (shift_i) begin
            data_d = {byte_i, data_q[8*NumBytes-1:8]};
            cnt_d  = done_o ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/blackparrot_fpga_host_byte_to_axil.sv
// Parses host command bytes into single AXI4-Lite transactions and streams back data/status.
// BLACKPARROT_FPGA_HOST_CMD_CHECKSUM_EN enables the trailing XOR checksum byte check.
module blackparrot_fpga_host_byte_to_axil
    import blackparrot_fpga_host_pkg::*;
#(
    parameter int unsigned M_AXIL_ADDR_WIDTH = 64,
    parameter int unsigned M_AXIL_DATA_WIDTH = 32
) (
    input  logic                           m_axil_aclk,
    input  logic                           m_axil_aresetn,

    input  logic                           cmd_v_i,
    input  logic [7:0]                     cmd_data_i,
    output logic                           cmd_ready_and_o,

    output logic                           resp_v_o,
    output logic [7:0]                     resp_data_o,
    input  logic                           resp_ready_and_i,

    output logic [M_AXIL_ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic                           m_axil_awvalid,
    input  logic                           m_axil_awready,
    output logic [2:0]                     m_axil_awprot,

    output logic [M_AXIL_DATA_WIDTH-1:0]   m_axil_wdata,
    output logic                           m_axil_wvalid,
    input  logic                           m_axil_wready,
    output logic [M_AXIL_DATA_WIDTH/8-1:0] m_axil_wstrb,

    input  logic                           m_axil_bvalid,
    output logic                           m_axil_bready,
    input  logic [1:0]                     m_axil_bresp,

    output logic [M_AXIL_ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic                           m_axil_arvalid,
    input  logic                           m_axil_arready,
    output logic [2:0]                     m_axil_arprot,

    input  logic [M_AXIL_DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic                           m_axil_rvalid,
    output logic                           m_axil_rready,
    input  logic [1:0]                     m_axil_rresp
);

    state_e      state_d, state_q;
    logic        is_write_d, is_write_q;
    logic        aw_done_d, aw_done_q;
    logic        w_done_d, w_done_q;
    logic [7:0]  status_d, status_q;
    logic [31:0] rdata_d, rdata_q;
    logic [1:0]  rd_cnt_d, rd_cnt_q;
    logic [1:0]  rd_byte_idx;
    logic        cmd_ready_d, cmd_ready_q;
    logic        resp_v_d, resp_v_q;
    logic [7:0]  resp_data_d, resp_data_q;
    logic        awvalid_d, awvalid_q;
    logic        wvalid_d, wvalid_q;
    logic        bready_d, bready_q;
    logic        arvalid_d, arvalid_q;
    logic        rready_d, rready_q;
`ifdef BLACKPARROT_FPGA_HOST_CMD_CHECKSUM_EN
    logic [7:0]  csum_d, csum_q;
`endif

    logic        cmd_hs, resp_hs;
    logic        aw_hs, w_hs;
    logic        addr_done, data_done;
    logic [31:0] addr_w, data_w;

    assign cmd_hs  = cmd_v_i && cmd_ready_q;
    assign resp_hs = resp_v_q && resp_ready_and_i;
    assign aw_hs   = awvalid_q && m_axil_awready;
    assign w_hs    = wvalid_q && m_axil_wready;
    assign rd_byte_idx = rd_cnt_q + 2'd1;

    blackparrot_fpga_host_byte_sipo #(
        .NumBytes (AddrBytes)
    ) u_addr_sipo (
        .clk_i   (m_axil_aclk),
        .rst_ni  (m_axil_aresetn),
        .clr_i   (state_q == StIdle),
        .shift_i (cmd_hs && (state_q == StAddr)),
        .byte_i  (cmd_data_i),
        .data_o  (addr_w),
        .done_o  (addr_done)
    );

    blackparrot_fpga_host_byte_sipo #(
        .NumBytes (DataBytes)
    ) u_data_sipo (
        .clk_i   (m_axil_aclk),
        .rst_ni  (m_axil_aresetn),
        .clr_i   (state_q == StIdle),
        .shift_i (cmd_hs && (state_q == StData)),
        .byte_i  (cmd_data_i),
        .data_o  (data_w),
        .done_o  (data_done)
    );

    always_comb begin
        m_axil_awaddr       = '0;
        m_axil_awaddr[31:0] = addr_w;
        m_axil_araddr       = '0;
        m_axil_araddr[31:0] = addr_w;
    end

    assign m_axil_wdata    = data_w;
    assign m_axil_wstrb    = '1;
    assign m_axil_awprot   = 3'b000;
    assign m_axil_arprot   = 3'b000;
    assign m_axil_awvalid  = awvalid_q;
    assign m_axil_wvalid   = wvalid_q;
    assign m_axil_bready   = bready_q;
    assign m_axil_arvalid  = arvalid_q;
    assign m_axil_rready   = rready_q;
    assign cmd_ready_and_o = cmd_ready_q;
    assign resp_v_o        = resp_v_q;
    assign resp_data_o     = resp_data_q;

    always_comb begin
        state_d     = state_q;
        is_write_d  = is_write_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        status_d    = status_q;
        rdata_d     = rdata_q;
        rd_cnt_d    = rd_cnt_q;
        cmd_ready_d = cmd_ready_q;
        resp_v_d    = resp_v_q;
        resp_data_d = resp_data_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
`ifdef BLACKPARROT_FPGA_HOST_CMD_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (cmd_hs) begin
`ifdef BLACKPARROT_FPGA_HOST_CMD_CHECKSUM_EN
                    csum_d = cmd_data_i;
`endif
                    if (cmd_data_i == OpWrite || cmd_data_i == OpRead) begin
                        state_d    = StAddr;
                        is_write_d = (cmd_data_i == OpWrite);
                    end else begin
                        state_d     = StStatus;
                        status_d    = StatusUnknown;
                        cmd_ready_d = 1'b0;
                        resp_v_d    = 1'b1;
                        resp_data_d = StatusUnknown;
                    end
                end
            end
            StAddr: begin
                if (cmd_hs) begin
`ifdef BLACKPARROT_FPGA_HOST_CMD_CHECKSUM_EN
                    csum_d = csum_q ^ cmd_data_i;
                    if (addr_done) begin
                        state_d = is_write_q ? StData : StCsum;
                    end
`else
                    if (addr_done && is_write_q) begin
                        state_d = StData;
                    end else if (addr_done) begin
                        state_d     = StRead;
                        cmd_ready_d = 1'b0;
                        arvalid_d   = 1'b1;
                    end
`endif
                end
            end
            StData: begin
                if (cmd_hs) begin
`ifdef BLACKPARROT_FPGA_HOST_CMD_CHECKSUM_EN
                    csum_d = csum_q ^ cmd_data_i;
                    if (data_done) begin
                        state_d = StCsum;
                    end
`else
                    if (data_done) begin
                        state_d     = StWrite;
                        cmd_ready_d = 1'b0;
                        awvalid_d   = 1'b1;
                        wvalid_d    = 1'b1;
                        aw_done_d   = 1'b0;
                        w_done_d    = 1'b0;
                    end
`endif
                end
            end
`ifdef BLACKPARROT_FPGA_HOST_CMD_CHECKSUM_EN
            StCsum: begin
                if (cmd_hs) begin
                    cmd_ready_d = 1'b0;
                    if (cmd_data_i != csum_q) begin
                        state_d     = StStatus;
                        status_d    = StatusCsumErr;
                        resp_v_d    = 1'b1;
                        resp_data_d = StatusCsumErr;
                    end else if (is_write_q) begin
                        state_d   = StWrite;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = StRead;
                        arvalid_d = 1'b1;
                    end
                end
            end
`endif
            StWrite: begin
                // AW and W complete independently; leave only once both have handshaken.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d  = StBwait;
                    bready_d = 1'b1;
                end
            end
            StBwait: begin
                if (bready_q && m_axil_bvalid) begin
                    state_d     = StStatus;
                    bready_d    = 1'b0;
                    status_d    = {6'b0, m_axil_bresp};
                    resp_v_d    = 1'b1;
                    resp_data_d = {6'b0, m_axil_bresp};
                end
            end
            StRead: begin
                if (arvalid_q && m_axil_arready) begin
                    state_d   = StRwait;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            StRwait: begin
                if (rready_q && m_axil_rvalid) begin
                    state_d     = StRdata;
                    rready_d    = 1'b0;
                    rdata_d     = m_axil_rdata[31:0];
                    status_d    = {6'b0, m_axil_rresp};
                    rd_cnt_d    = 2'd0;
                    resp_v_d    = 1'b1;
                    resp_data_d = m_axil_rdata[7:0];
                end
            end
            StRdata: begin
                if (resp_hs) begin
                    if (rd_cnt_q == 2'd3) begin
                        state_d     = StStatus;
                        resp_data_d = status_q;
                    end else begin
                        rd_cnt_d    = rd_byte_idx;
                        resp_data_d = rdata_q[{rd_byte_idx, 3'b000} +: 8];
                    end
                end
            end
            StStatus: begin
                if (resp_hs) begin
                    state_d     = StIdle;
                    resp_v_d    = 1'b0;
                    resp_data_d = 8'h00;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = StIdle;
                cmd_ready_d = 1'b1;
                resp_v_d    = 1'b0;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge m_axil_aclk or negedge m_axil_aresetn) begin
        if (!m_axil_aresetn) begin
            state_q     <= StIdle;
            is_write_q  <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            status_q    <= 8'h00;
            rdata_q     <= 32'h0;
            rd_cnt_q    <= 2'd0;
            cmd_ready_q <= 1'b1;
            resp_v_q    <= 1'b0;
            resp_data_q <= 8'h00;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
`ifdef BLACKPARROT_FPGA_HOST_CMD_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            is_write_q  <= is_write_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            status_q    <= status_d;
            rdata_q     <= rdata_d;
            rd_cnt_q    <= rd_cnt_d;
            cmd_ready_q <= cmd_ready_d;
            resp_v_q    <= resp_v_d;
            resp_data_q <= resp_data_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
`ifdef BLACKPARROT_FPGA_HOST_CMD_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

endmodule
